// File: rtl/filter_arbiter.sv
// Two 1-entry sample buffers share one filter: round-robin issue, result LAT+1 cycles after issue.
// Inputs stall through x_ready while a buffer is occupied; results are never stalled.
module filter_arbiter #(
  parameter int DW  = 5,
  parameter int LAT = 4,
  parameter int GAP = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          i_ready,
  input  logic          q_valid,
  input  logic [DW-1:0] q_data,
  output logic          q_ready,
  output logic          flt_en,
  output logic          flt_ch,
  output logic [DW-1:0] flt_in,
  input  logic [DW-1:0] flt_out,
  output logic          i_out_valid,
  output logic [DW-1:0] i_out_data,
  output logic          q_out_valid,
  output logic [DW-1:0] q_out_data,
  output logic          busy
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

  logic           i_full, q_full;
  logic [DW-1:0]  i_buf, q_buf;
  logic [3:0]     gap_cnt;
  logic           last_q;
  logic           issue, grant_q;
  logic [LAT-1:0] tag_vld, tag_ch;

  assign i_ready = ~i_full;
  assign q_ready = ~q_full;
  assign issue   = (gap_cnt == 4'd0) && (i_full || q_full);
  // On a tie, prefer the channel that did not win last time.
  assign grant_q = q_full && (!i_full || !last_q);
  assign busy    = i_full | q_full | (|tag_vld);

  // Accept and issue never coincide on one buffer: accept needs empty, issue needs full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_full <= 1'b0;
      q_full <= 1'b0;
      i_buf  <= '0;
      q_buf  <= '0;
    end else begin
      if (i_valid && i_ready) begin
        i_full <= 1'b1;
        i_buf  <= i_data;
      end else if (issue && !grant_q) begin
        i_full <= 1'b0;
      end
      if (q_valid && q_ready) begin
        q_full <= 1'b1;
        q_buf  <= q_data;
      end else if (issue && grant_q) begin
        q_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flt_en  <= 1'b0;
      flt_ch  <= 1'b0;
      flt_in  <= '0;
      gap_cnt <= 4'd0;
      last_q  <= 1'b1;
    end else if (issue) begin
      flt_en  <= 1'b1;
      flt_ch  <= grant_q;
      flt_in  <= grant_q ? q_buf : i_buf;
      gap_cnt <= GAP_LOAD;
      last_q  <= grant_q;
    end else begin
      flt_en <= 1'b0;
      if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
    end
  end

  // Stage k holds the issue from LAT-related cycle t, valid during cycle t+1+k.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld <= '0;
      tag_ch  <= '0;
    end else begin
      tag_vld[0] <= flt_en;
      tag_ch[0]  <= flt_ch;
      for (int k = 1; k < LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_ch[k]  <= tag_ch[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_out_valid <= 1'b0;
      q_out_valid <= 1'b0;
      i_out_data  <= '0;
      q_out_data  <= '0;
    end else begin
      i_out_valid <= tag_vld[LAT-1] && !tag_ch[LAT-1];
      q_out_valid <= tag_vld[LAT-1] && tag_ch[LAT-1];
      if (tag_vld[LAT-1] && !tag_ch[LAT-1]) i_out_data <= flt_out;
      if (tag_vld[LAT-1] && tag_ch[LAT-1])  q_out_data <= flt_out;
    end
  end

endmodule

// File: tb/tb_filter_arbiter.sv
// Bench for filter_arbiter: vector table, directed corner sequences and a randomized run
// against a cycle-level reference model; the filter is emulated as flt_in ^ mask after LAT cycles.
`timescale 1ns/1ps
module tb_filter_arbiter;
  localparam int DW = 5, LAT = 4, GAP = 1, GAP3 = 3;

  logic clk = 1'b0;
  logic reset;
  logic i_valid = 1'b0, q_valid = 1'b0;
  logic [DW-1:0] i_data = '0, q_data = '0, flt_out = '0, zero_dat = '0;
  logic i_ready, q_ready, flt_en, flt_ch, i_out_valid, q_out_valid, busy;
  logic [DW-1:0] flt_in, i_out_data, q_out_data;
  logic g3_i_ready, g3_q_ready, g3_flt_en, g3_flt_ch, g3_iov, g3_qov, g3_busy;
  logic [DW-1:0] g3_flt_in, g3_iod, g3_qod;

  filter_arbiter #(.DW(DW), .LAT(LAT), .GAP(GAP)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
    .q_valid(q_valid), .q_data(q_data), .q_ready(q_ready),
    .flt_en(flt_en), .flt_ch(flt_ch), .flt_in(flt_in), .flt_out(flt_out),
    .i_out_valid(i_out_valid), .i_out_data(i_out_data),
    .q_out_valid(q_out_valid), .q_out_data(q_out_data), .busy(busy));

  filter_arbiter #(.DW(DW), .LAT(LAT), .GAP(GAP3)) dut3 (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_data(i_data), .i_ready(g3_i_ready),
    .q_valid(q_valid), .q_data(q_data), .q_ready(g3_q_ready),
    .flt_en(g3_flt_en), .flt_ch(g3_flt_ch), .flt_in(g3_flt_in), .flt_out(zero_dat),
    .i_out_valid(g3_iov), .i_out_data(g3_iod),
    .q_out_valid(g3_qov), .q_out_data(g3_qod), .busy(g3_busy));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  bit chk_model = 1'b0;
  logic [DW-1:0] mask = 5'h04;

  typedef struct { int cyc; int ch; int dat; } ev_t;
  ev_t res_log[$];
  ev_t iss_log[$];

  bit            hist_en[64];
  logic [DW-1:0] hist_in[64];

  // Reference model: buffers, spacing and round-robin as plain variables, results scheduled by absolute cycle.
  int            m_full[2];
  logic [DW-1:0] m_data[2];
  int            m_gap, m_last;
  logic          m_en, m_ch, m_iov, m_qov, m_busy;
  logic [DW-1:0] m_in, m_iod, m_qod;
  int            issue_q[$];
  bit            due_v[64];
  bit            due_ch[64];
  logic [DW-1:0] due_d[64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_full[0] = 0; m_full[1] = 0; m_data[0] = '0; m_data[1] = '0;
    m_gap = 0; m_last = 1;
    m_en = 0; m_ch = 0; m_in = '0; m_iov = 0; m_qov = 0; m_iod = '0; m_qod = '0; m_busy = 0;
    issue_q.delete();
    for (int k = 0; k < 64; k++) begin due_v[k] = 0; hist_en[k] = 0; end
  endfunction

  function automatic void model_step(bit iv, logic [DW-1:0] id, bit qv, logic [DW-1:0] qd);
    bit acc_i, acc_q;
    int ch, s;
    acc_i = iv && (m_full[0] == 0);
    acc_q = qv && (m_full[1] == 0);
    m_en = 0;
    if (m_gap == 0 && (m_full[0] != 0 || m_full[1] != 0)) begin
      if (m_full[0] != 0 && m_full[1] != 0) ch = 1 - m_last;
      else ch = m_full[1];
      m_en = 1; m_ch = ch[0]; m_in = m_data[ch];
      m_full[ch] = 0; m_last = ch; m_gap = GAP - 1;
      s = (cyc + LAT + 1) % 64;
      due_v[s] = 1; due_ch[s] = ch[0]; due_d[s] = m_in ^ mask;
      issue_q.push_back(cyc);
    end else if (m_gap > 0) begin
      m_gap--;
    end
    if (acc_i) begin m_full[0] = 1; m_data[0] = id; end
    if (acc_q) begin m_full[1] = 1; m_data[1] = qd; end
    s = cyc % 64;
    m_iov = due_v[s] && !due_ch[s];
    m_qov = due_v[s] && due_ch[s];
    if (m_iov) m_iod = due_d[s];
    if (m_qov) m_qod = due_d[s];
    due_v[s] = 0;
    while (issue_q.size() > 0 && issue_q[0] + LAT < cyc) void'(issue_q.pop_front());
    m_busy = (m_full[0] != 0) || (m_full[1] != 0) || (issue_q.size() > 0 && issue_q[0] < cyc);
  endfunction

  task automatic model_check();
    chk("i_ready", i_ready, m_full[0] == 0);
    chk("q_ready", q_ready, m_full[1] == 0);
    chk("flt_en", flt_en, m_en);
    chk("flt_ch", flt_ch, m_ch);
    chk("flt_in", flt_in, m_in);
    chk("i_out_valid", i_out_valid, m_iov);
    chk("i_out_data", i_out_data, m_iod);
    chk("q_out_valid", q_out_valid, m_qov);
    chk("q_out_data", q_out_data, m_qod);
    chk("busy", busy, m_busy);
  endtask

  task automatic tick(input bit iv, input logic [DW-1:0] id, input bit qv, input logic [DW-1:0] qd);
    i_valid = iv; i_data = id; q_valid = qv; q_data = qd;
    @(posedge clk);
    cyc++;
    model_step(iv, id, qv, qd);
    #1;
    if (cyc >= LAT && hist_en[(cyc - LAT) % 64]) flt_out = hist_in[(cyc - LAT) % 64] ^ mask;
    else flt_out = DW'($urandom);
    @(negedge clk);
    hist_en[cyc % 64] = flt_en;
    hist_in[cyc % 64] = flt_in;
    if (flt_en) iss_log.push_back('{cyc, int'(flt_ch), int'(flt_in)});
    if (i_out_valid) res_log.push_back('{cyc, 0, int'(i_out_data)});
    if (q_out_valid) res_log.push_back('{cyc, 1, int'(q_out_data)});
    if (chk_model) model_check();
  endtask

  task automatic do_reset();
    i_valid = 0; q_valid = 0; reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
    res_log.delete(); iss_log.delete();
  endtask

  typedef struct {
    bit iv; int id; bit qv; int qd;
    bit en; bit ch; int fin; bit ir; bit qr;
    bit iov; int iod; bit qov; int qod; bit bsy;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int base;
    // Continuous offers on both channels, mask 4: tie goes to I first, then strict alternation.
    tbl[0] = '{1, 1, 1, 17, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1};
    tbl[1] = '{1, 2, 1, 18, 1, 0,  1, 1, 0, 0, 0, 0,  0, 1};
    tbl[2] = '{1, 3, 1, 19, 1, 1, 17, 0, 1, 0, 0, 0,  0, 1};
    tbl[3] = '{1, 4, 1, 20, 1, 0,  3, 1, 0, 0, 0, 0,  0, 1};
    tbl[4] = '{1, 5, 1, 21, 1, 1, 20, 0, 1, 0, 0, 0,  0, 1};
    tbl[5] = '{1, 6, 1, 22, 1, 0,  5, 1, 0, 0, 0, 0,  0, 1};
    tbl[6] = '{1, 7, 1, 23, 1, 1, 22, 0, 1, 1, 5, 0,  0, 1};
    tbl[7] = '{1, 8, 1, 24, 1, 0,  7, 1, 0, 0, 5, 1, 21, 1};
    tbl[8] = '{1, 9, 1, 25, 1, 1, 24, 0, 1, 1, 7, 0, 21, 1};
    tbl[9] = '{1, 10, 1, 26, 1, 0, 9, 1, 0, 0, 7, 1, 16, 1};

    reset = 1;
    #1;
    chk("rst_flt_en", flt_en, 0);
    chk("rst_flt_ch", flt_ch, 0);
    chk("rst_flt_in", flt_in, 0);
    chk("rst_i_ready", i_ready, 1);
    chk("rst_q_ready", q_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", {i_out_valid, q_out_valid}, 0);
    chk("rst_out_data", {i_out_data, q_out_data}, 0);

    mask = 5'h04;
    do_reset();
    chk_model = 0;
    for (int r = 0; r < 10; r++) begin
      tick(tbl[r].iv, DW'(tbl[r].id), tbl[r].qv, DW'(tbl[r].qd));
      chk("tbl_flt_en", flt_en, tbl[r].en);
      chk("tbl_flt_ch", flt_ch, tbl[r].ch);
      chk("tbl_flt_in", flt_in, tbl[r].fin);
      chk("tbl_ready", {i_ready, q_ready}, {tbl[r].ir, tbl[r].qr});
      chk("tbl_i_out", {i_out_valid, i_out_data}, {tbl[r].iov, DW'(tbl[r].iod)});
      chk("tbl_q_out", {q_out_valid, q_out_data}, {tbl[r].qov, DW'(tbl[r].qod)});
      chk("tbl_busy", busy, tbl[r].bsy);
    end
    chk_model = 1;
    repeat (8) tick(0, 0, 0, 0);

    // Single I sample 3 -> result 7 (mask 4), LAT+1 cycles after its issue.
    do_reset();
    base = cyc;
    tick(1, 3, 0, 0);
    tick(0, 0, 0, 0);
    chk("single_issue", {flt_en, flt_ch, flt_in}, {1'b1, 1'b0, 5'd3});
    repeat (10) tick(0, 0, 0, 0);
    chk("single_res_cnt", res_log.size(), 1);
    if (res_log.size() == 1 && iss_log.size() == 1) begin
      chk("single_res_ch", res_log[0].ch, 0);
      chk("single_res_dat", res_log[0].dat, 7);
      chk("single_iss_cyc", iss_log[0].cyc - base, 2);
      chk("single_lat", res_log[0].cyc - iss_log[0].cyc, LAT + 1);
    end

    // Interleaved I=1, Q=2, I=3 with an identity filter.
    mask = 5'h00;
    do_reset();
    tick(1, 1, 0, 0);
    tick(0, 0, 1, 2);
    tick(1, 3, 0, 0);
    repeat (12) tick(0, 0, 0, 0);
    chk("ilv_res_cnt", res_log.size(), 3);
    chk("ilv_iss_cnt", iss_log.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < res_log.size() && k < iss_log.size()) begin
        chk("ilv_res_ch", res_log[k].ch, (k == 1) ? 1 : 0);
        chk("ilv_res_dat", res_log[k].dat, k + 1);
        chk("ilv_lat", res_log[k].cyc - iss_log[k].cyc, LAT + 1);
      end
    end

    // GAP=3 instance with I offered every cycle: issues at relative cycles 2,5,8,...
    do_reset();
    base = 0;
    for (int r = 1; r <= 20; r++) begin
      tick(1, DW'(r), 0, 0);
      chk("gap3_en", g3_flt_en, (r >= 2) && ((r - 2) % 3 == 0));
      chk("gap3_ready", g3_i_ready, (r >= 2) && ((r - 2) % 3 == 0));
      if (g3_flt_en) base++;
    end
    chk("gap3_count", base, 7);
    repeat (8) tick(0, 0, 0, 0);

    // Reset two cycles after an issue: in-flight result must vanish.
    do_reset();
    tick(1, 9, 0, 0);
    tick(0, 0, 0, 0);
    chk("mid_issue", flt_en, 1);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    reset = 1;
    #1;
    chk("mid_rst_ready", {i_ready, q_ready}, 2'b11);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_flt_en", flt_en, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
    res_log.delete();
    repeat (10) tick(0, 0, 0, 0);
    chk("mid_rst_no_res", res_log.size(), 0);

    // Randomized traffic with varying offer density.
    mask = 5'h0A;
    for (int k = 0; k < 1500; k++) begin
      int dens;
      dens = (k / 250) % 3;
      tick($urandom_range(0, 3) < dens + 1, DW'($urandom), $urandom_range(0, 3) < 3 - dens, DW'($urandom));
    end
    repeat (10) tick(0, 0, 0, 0);

    // Idle: nothing issued, nothing busy.
    for (int k = 0; k < 100; k++) begin
      tick(0, DW'($urandom), 0, DW'($urandom));
      chk("idle_flt_en", flt_en, 0);
      chk("idle_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_arbiter.md
FILTER_ARBITER -- requirements
Module: filter_arbiter

Interface
REQ-001 Parameter DW, default 5, sample width of ADC data and filter data.
REQ-002 Parameter LAT, default 4, shared-filter latency in cycles from flt_en to valid flt_out (legal 1..15).
REQ-003 Parameter GAP, default 1, minimum cycles between successive flt_en pulses (legal 1..15).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 i_valid  input  1  I-channel sample offered.
REQ-007 i_data  input  DW  I-channel sample.
REQ-008 i_ready  output  1  I-channel input buffer can accept.
REQ-009 q_valid  input  1  Q-channel sample offered.
REQ-010 q_data  input  DW  Q-channel sample.
REQ-011 q_ready  output  1  Q-channel input buffer can accept.
REQ-012 flt_en  output  1  one-cycle issue strobe to the shared filter.
REQ-013 flt_ch  output  1  channel of the issued sample (0 = I, 1 = Q).
REQ-014 flt_in  output  DW  sample presented to the filter.
REQ-015 flt_out  input  DW  filter result, valid LAT cycles after its flt_en.
REQ-016 i_out_valid / i_out_data  output  1 / DW  I-channel filtered result.
REQ-017 q_out_valid / q_out_data  output  1 / DW  Q-channel filtered result.
REQ-018 busy  output  1  any input buffer full or any result in flight.

Function
REQ-019 Each channel SHALL have a 1-entry buffer; x_ready SHALL equal NOT buffer-full (combinational from the flag).
REQ-020 A transfer SHALL occur on a rising edge with x_valid=1 and x_ready=1; the buffer SHALL capture x_data and set full.
REQ-021 The gap counter SHALL be 4 bits; an issue is permitted only when it equals 0.
REQ-022 Issue rule: gap counter 0 and at least one buffer full -> grant one channel, registered flt_en=1 for exactly one cycle, flt_ch and flt_in driven from the granted buffer.
REQ-023 Only one full -> grant it; both full -> grant the channel not granted last (round-robin).
REQ-024 The last-grant flag SHALL reset to Q, so the first tie after reset grants I.
REQ-025 The granted buffer SHALL clear on the issuing edge; it is refilled no earlier than the following edge (no same-edge accept and issue on one buffer).
REQ-026 On issue the gap counter SHALL load GAP-1 and decrement by 1 per cycle to 0; GAP=1 allows back-to-back issues every cycle.
REQ-027 flt_en=0 -> flt_ch and flt_in SHALL hold their last values.
REQ-028 A LAT-deep shift register SHALL carry {valid, ch} per issue; flt_out SHALL be sampled on the edge ending cycle t+LAT for an issue in cycle t.
REQ-029 The selected x_out_valid SHALL pulse for one cycle in cycle t+LAT+1 with x_out_data = sampled flt_out; the other channel's valid stays 0.
REQ-030 x_out_data SHALL hold its value until the next result for that channel.
REQ-031 No backpressure on results: every issued sample SHALL produce exactly one result, in issue order.
REQ-032 busy SHALL be 1 when either buffer is full or any tag-pipeline stage is valid, else 0.

Reset
REQ-033 On reset assertion, all outputs SHALL go to 0 asynchronously except i_ready=q_ready=1: flt_en, flt_ch, flt_in, x_out_valid, x_out_data, busy.
REQ-034 Reset mid-operation SHALL clear buffers, gap counter and tag pipeline; in-flight results are discarded and no x_out_valid pulse follows deassertion.
REQ-035 The first issue SHALL occur no earlier than the first edge after a buffer fills following reset deassertion.

Verification
REQ-036 Single I sample 0x03 accepted at edge E (LAT=4, GAP=1): flt_en=1, flt_ch=0, flt_in=3 in the cycle after E; flt_out driven 0x07 four cycles later -> i_out_valid pulses one cycle with i_out_data=7.
REQ-037 Both buffers full simultaneously after reset -> I issued first, Q next cycle; continuous offers on both -> strict I,Q,I,Q alternation on flt_ch.
REQ-038 GAP=3, I offered every cycle -> flt_en exactly every 3 cycles; i_ready low while the buffer waits.
REQ-039 Interleaved I=1, Q=2, I=3 with flt_out mirroring flt_in -> results 1 (I), 2 (Q), 3 (I), each LAT+1 cycles after its issue.
REQ-040 Reset asserted 2 cycles after an issue -> no x_out_valid afterwards, busy=0, i_ready=q_ready=1 immediately.
REQ-041 Idle with no offers -> flt_en stays 0 and busy=0 for 100 cycles.
